// File: rtl/sram_read_aligner.sv
// rtl/sram_read_aligner.sv - gathers SRAM read beats, extracts an aligned field and sign/zero-extends it
module sram_read_aligner #(
    parameter int WORD_W    = 8,
    parameter int BEATS_MAX = 4,
    localparam int OUT_W    = WORD_W * BEATS_MAX,
    localparam int ADDR_W   = $clog2(WORD_W),
    localparam int SZ_MAX   = $clog2(OUT_W),
    localparam int SZ_W     = $clog2(SZ_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [SZ_W-1:0]   req_size,
    input  logic              req_signed,
    input  logic              rsp_valid,
    input  logic [WORD_W-1:0] rsp_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              err
);

    localparam int CNT_W = (BEATS_MAX > 1) ? $clog2(BEATS_MAX) : 1;
    localparam int WB_W  = SZ_MAX + 1;

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  last_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [SZ_W-1:0]   sz_q;
    logic              sgn_q;
    logic [OUT_W-1:0]  buf_q;
    logic [OUT_W-1:0]  assembled;
    logic [OUT_W-1:0]  raw;
    logic [OUT_W-1:0]  result;
    logic [ADDR_W-1:0] shift;
    logic [WB_W-1:0]   w_bits;
    logic              single;
    logic              sbit;

    assign req_ready = (state == IDLE);
    assign single    = (int'(sz_q) <= ADDR_W);

    // Index of the final beat: 0 for sub-word accesses, W/WORD_W-1 otherwise
    always_comb begin
        last_cnt = '0;
        if (!single)
            last_cnt = CNT_W'((1 << (int'(sz_q) - ADDR_W)) - 1);
    end

    // Collected beats with the current beat merged into its slot
    always_comb begin
        assembled = buf_q;
        for (int b = 0; b < BEATS_MAX; b++) begin
            if (CNT_W'(b) == cnt)
                assembled[b*WORD_W +: WORD_W] = rsp_data;
        end
    end

    // Field extraction and extension from bit W-1; high address bits drop out of the shift
    always_comb begin
        shift  = ADDR_W'(int'(addr_q) << sz_q);
        w_bits = WB_W'(1) << sz_q;
        raw    = single ? OUT_W'(rsp_data >> shift) : assembled;
        result = '0;
        sbit   = 1'b0;
        for (int i = 0; i < OUT_W; i++) begin
            if (i < int'(w_bits)) begin
                result[i] = raw[i];
                sbit      = raw[i];
            end else begin
                result[i] = sgn_q & sbit;
            end
        end
    end

    // Control FSM with registered result, beat counter and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            sz_q      <= '0;
            sgn_q     <= 1'b0;
            buf_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rsp_valid)
                        err <= 1'b1;
                    if (!flush && req_valid) begin
                        addr_q <= req_addr;
                        sgn_q  <= req_signed;
                        cnt    <= '0;
                        if (req_size > SZ_W'(SZ_MAX)) begin
                            sz_q <= SZ_W'(SZ_MAX);
                            err  <= 1'b1;
                        end else begin
                            sz_q <= req_size;
                        end
                        state <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (flush) begin
                        cnt       <= '0;
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end else if (rsp_valid) begin
                        buf_q <= assembled;
                        if (cnt == last_cnt) begin
                            out_data  <= result;
                            out_valid <= 1'b1;
                            cnt       <= '0;
                            state     <= HOLD;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (flush) begin
                        cnt       <= '0;
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        if (rsp_valid)
                            err <= 1'b1;
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_read_aligner.sv
// tb/tb_sram_read_aligner.sv - table-driven scoreboard bench for sram_read_aligner
module tb_sram_read_aligner;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_addr;
    logic [2:0]  req_size;
    logic        req_signed;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] sb_q[$];

    typedef struct {
        logic [2:0]  size;
        logic [2:0]  addr;
        logic        sgn;
        int          nb;
        logic [31:0] beats;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[11];

    sram_read_aligner #(.WORD_W(8), .BEATS_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic collect_result(input string name);
        int cyc = 0;
        logic [31:0] e;
        while (!out_valid && cyc < 20) begin
            step();
            cyc++;
        end
        if (!out_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got out_valid=0 expected 1", name);
            if (sb_q.size() > 0) e = sb_q.pop_front();
        end else if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_sb_empty: got result %h expected none", name, out_data);
        end else begin
            e = sb_q.pop_front();
            check(name, out_data, e);
        end
    endtask

    task automatic run_access(input vec_t v, input string name);
        check({name, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_size   = v.size;
        req_addr   = v.addr;
        req_signed = v.sgn;
        step();
        req_valid = 1'b0;
        sb_q.push_back(v.exp);
        for (int b = 0; b < v.nb; b++) begin
            rsp_valid = 1'b1;
            rsp_data  = v.beats[b*8 +: 8];
            check({name, "_early"}, {31'd0, out_valid}, 32'd0);
            step();
        end
        rsp_valid = 1'b0;
        check({name, "_latency"}, {31'd0, out_valid}, 32'd1);
        collect_result({name, "_data"});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({name, "_back_idle"}, {31'd0, req_ready}, 32'd1);
        check({name, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        vt[0]  = '{3'd1, 3'd3, 1'b1, 1, 32'h00000080, 32'hFFFFFFFE};
        vt[1]  = '{3'd2, 3'd1, 1'b0, 1, 32'h000000A5, 32'h0000000A};
        vt[2]  = '{3'd2, 3'd0, 1'b0, 1, 32'h000000A5, 32'h00000005};
        vt[3]  = '{3'd4, 3'd0, 1'b1, 2, 32'h00008034, 32'hFFFF8034};
        vt[4]  = '{3'd5, 3'd0, 1'b0, 4, 32'h12345678, 32'h12345678};
        vt[5]  = '{3'd0, 3'd5, 1'b1, 1, 32'h00000020, 32'hFFFFFFFF};
        vt[6]  = '{3'd3, 3'd7, 1'b1, 1, 32'h0000007F, 32'h0000007F};
        vt[7]  = '{3'd3, 3'd0, 1'b1, 1, 32'h00000080, 32'hFFFFFF80};
        vt[8]  = '{3'd2, 3'd3, 1'b1, 1, 32'h0000009C, 32'hFFFFFFF9};
        vt[9]  = '{3'd4, 3'd6, 1'b0, 2, 32'h00008034, 32'h00008034};
        vt[10] = '{3'd7, 3'd0, 1'b0, 4, 32'h12345678, 32'h12345678};

        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_size = '0; req_signed = 1'b0;
        rsp_valid = 1'b0; rsp_data = '0; flush = 1'b0; out_ready = 1'b0;
        step();
        step();
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 10; i++)
            run_access(vt[i], $sformatf("vec%0d", i));
        check("err_after_table", {31'd0, err}, 32'd0);

        // result held while consumer stalls
        req_valid = 1'b1; req_size = 3'd2; req_addr = 3'd0; req_signed = 1'b0;
        step();
        req_valid = 1'b0;
        sb_q.push_back(32'h00000005);
        rsp_valid = 1'b1; rsp_data = 8'hA5;
        step();
        rsp_valid = 1'b0;
        check("hold_latency", {31'd0, out_valid}, 32'd1);
        collect_result("hold_data");
        for (int c = 0; c < 5; c++) begin
            check("hold_stable", out_data, 32'h00000005);
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_req_ready", {31'd0, req_ready}, 32'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("hold_release", {31'd0, req_ready}, 32'd1);

        // flush in IDLE overrides a request
        req_valid = 1'b1; flush = 1'b1; req_size = 3'd4;
        step();
        req_valid = 1'b0; flush = 1'b0;
        check("idle_flush_no_accept", {31'd0, req_ready}, 32'd1);

        // flush after first of two beats, second beat arriving with the flush
        req_valid = 1'b1; req_size = 3'd4; req_signed = 1'b1;
        step();
        req_valid = 1'b0;
        rsp_valid = 1'b1; rsp_data = 8'h34;
        step();
        flush = 1'b1; rsp_data = 8'h80;
        step();
        flush = 1'b0; rsp_valid = 1'b0;
        check("flush_idle", {31'd0, req_ready}, 32'd1);
        check("flush_no_valid", {31'd0, out_valid}, 32'd0);
        step();
        step();
        check("flush_still_no_valid", {31'd0, out_valid}, 32'd0);
        check("flush_err_clear", {31'd0, err}, 32'd0);

        // stray beat in IDLE sets sticky err
        rsp_valid = 1'b1; rsp_data = 8'h11;
        step();
        rsp_valid = 1'b0;
        check("idle_beat_err", {31'd0, err}, 32'd1);
        step();
        step();
        step();
        check("err_sticky", {31'd0, err}, 32'd1);
        check("idle_beat_no_valid", {31'd0, out_valid}, 32'd0);

        // asynchronous reset mid-collect
        req_valid = 1'b1; req_size = 3'd5; req_signed = 1'b0;
        step();
        req_valid = 1'b0;
        rsp_valid = 1'b1; rsp_data = 8'hEE;
        step();
        step();
        rsp_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_ready", {31'd0, req_ready}, 32'd1);
        check("async_rst_err", {31'd0, err}, 32'd0);
        check("async_rst_data", out_data, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        run_access(vt[0], "post_rst");

        // oversize request clamps to full width and flags err
        run_access(vt[10], "oversize");
        check("oversize_err", {31'd0, err}, 32'd1);
        check("sb_drained", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
